fetch_pc_queue: RTL

- Parametrised next-generation fetch PC unit; replaces the single-step PC incrementer.
- Owns the fetch PC and issues in-order instruction fetch requests to memory with a valid/ready handshake.
- Tracks outstanding requests, buffers returned instructions in a QDEPTH-entry FIFO, and presents them to decode as (instr, pc, npc).
- Handles redirects from execute by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/fetch_pc_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_queue.sv
// Fetch PC unit: issues in-order fetch requests, buffers responses in a small FIFO
// and hands (instr, pc, npc) to decode; redirects flush the FIFO and drop stale responses.
module fetch_pc_queue #(
    parameter int               XLEN       = 64,
    parameter int               INST_BYTES = 4,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               QDEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    mem_req_valid,
    output logic [XLEN-1:0]         mem_req_addr,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [8*INST_BYTES-1:0] mem_resp_data,
    output logic                    if_id_valid,
    output logic [8*INST_BYTES-1:0] if_id_instr,
    output logic [XLEN-1:0]         if_id_pc,
    output logic [XLEN-1:0]         if_id_npc,
    input  logic                    if_id_ready
);

    localparam int IW = 8 * INST_BYTES;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;

    logic [IW-1:0]   instr_mem [QDEPTH];
    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [XLEN-1:0] npc_mem   [QDEPTH];

    logic credit_ok;
    logic req_fire;
    logic resp_fire;
    logic enq;
    logic deq;

    // Outstanding requests include stale ones, so a redirect cannot overrun the FIFO later.
    assign credit_ok     = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < (CW+1)'(QDEPTH);
    assign mem_req_valid = reset && !stall && credit_ok;
    assign mem_req_addr  = pc_reg;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is ignored entirely.
    assign resp_fire = mem_resp_valid && (outstanding_reg != '0);
    assign enq       = resp_fire && !redirect_valid && (drop_cnt_reg == '0);

    assign if_id_valid = (count_reg != '0) && !redirect_valid;
    assign deq         = if_id_valid && if_id_ready;
    assign if_id_instr = instr_mem[rd_ptr_reg];
    assign if_id_pc    = pc_mem[rd_ptr_reg];
    assign if_id_npc   = npc_mem[rd_ptr_reg];

    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(resp_fire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg          <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (redirect_valid) begin
                pc_reg       <= redirect_pc;
                resp_pc_reg  <= redirect_pc;
                drop_cnt_reg <= outstanding_next;
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + STEP;
                end
                if (resp_fire) begin
                    if (drop_cnt_reg != '0) begin
                        drop_cnt_reg <= drop_cnt_reg - 1'b1;
                    end else begin
                        resp_pc_reg <= resp_pc_reg + STEP;
                    end
                end
                if (enq) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (deq) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_reg + CW'(enq) - CW'(deq);
            end
        end
    end

    // npc is stored rather than derived so an empty, freshly reset FIFO reads all zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
                npc_mem[i]   <= '0;
            end
        end else if (enq) begin
            instr_mem[wr_ptr_reg] <= mem_resp_data;
            pc_mem[wr_ptr_reg]    <= resp_pc_reg;
            npc_mem[wr_ptr_reg]   <= resp_pc_reg + STEP;
        end
    end

    resp_without_request: assert property (
        @(posedge clk) disable iff (!reset) !(mem_resp_valid && (outstanding_reg == '0))
    );

endmodule
